// File: rtl/l2_tlb_refill_pkg.sv
// Shared widths, state encoding and payload types for the L2 TLB refill engine.
package l2_tlb_refill_pkg;

  localparam int unsigned WAYS        = 4;
  localparam int unsigned SETS        = 64;
  localparam int unsigned ASID_W      = 7;
  localparam int unsigned VPN_W       = 28;
  localparam int unsigned PPN_W       = 20;
  localparam int unsigned RR_W        = $clog2(WAYS);

  // Set index is the low VPN bits; the tag keeps VPN bits above the index up to bit 26.
  localparam int unsigned IDX_W       = $clog2(SETS);
  localparam int unsigned TAG_VPN_LSB = IDX_W;
  localparam int unsigned TAG_VPN_MSB = 26;
  localparam int unsigned TAG_VPN_W   = TAG_VPN_MSB - TAG_VPN_LSB + 1;
  localparam int unsigned TAG_W       = ASID_W + TAG_VPN_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FILL = 2'd3
  } state_e;

  typedef struct packed {
    logic [PPN_W-1:0] ppn;
    logic             v;
    logic             u;
    logic             sw;
    logic             d;
    logic             err;
  } ptw_resp_t;

endpackage

// File: rtl/l2_tlb_victim_sel.sv
// Picks the way to refill: lowest invalid way, else the round-robin pointer.
module l2_tlb_victim_sel
  import l2_tlb_refill_pkg::*;
(
  input  logic [WAYS-1:0] set_valid_i,
  input  logic [RR_W-1:0] rr_ptr_i,
  output logic [WAYS-1:0] victim_oh_o,
  output logic            uses_rr_o
);

  logic found;

  // Priority-encode the first free way; fall back to rr_ptr when the set is full.
  always_comb begin
    victim_oh_o = '0;
    found       = 1'b0;
    uses_rr_o   = &set_valid_i;
    for (int i = 0; i < int'(WAYS); i++) begin
      if (!set_valid_i[i] && !found) begin
        victim_oh_o[i] = 1'b1;
        found          = 1'b1;
      end
    end
    if (uses_rr_o) begin
      victim_oh_o = WAYS'(1) << rr_ptr_i;
    end
  end

endmodule

// File: rtl/l2_tlb_refill.sv
// L2 TLB refill engine: one walk per miss, single-cycle array fill, SFENCE handling.
module l2_tlb_refill
  import l2_tlb_refill_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              miss_valid,
  output logic              miss_ready,
  input  logic [VPN_W-1:0]  miss_vpn,
  input  logic [ASID_W-1:0] miss_asid,
  input  logic [WAYS-1:0]   set_valid,
  output logic              ptw_req_valid,
  input  logic              ptw_req_ready,
  output logic [VPN_W-1:0]  ptw_req_vpn,
  input  logic              ptw_resp_valid,
  input  logic [PPN_W-1:0]  ptw_resp_ppn,
  input  logic              ptw_resp_v,
  input  logic              ptw_resp_u,
  input  logic              ptw_resp_sw,
  input  logic              ptw_resp_d,
  input  logic              ptw_resp_err,
  input  logic              sfence_valid,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_set,
  output logic [WAYS-1:0]   wr_way_oh,
  output logic [TAG_W-1:0]  wr_tag,
  output logic              wr_valid,
  output logic              wr_u,
  output logic              wr_sw,
  output logic              wr_d,
  output logic [PPN_W-1:0]  wr_ppn,
  output logic              inval_all,
  output logic              done_valid,
  output logic              done_fault
);

  state_e             state_q, state_d;
  logic [VPN_W-1:0]   vpn_q, vpn_d;
  logic [ASID_W-1:0]  asid_q, asid_d;
  logic [WAYS-1:0]    victim_q, victim_d;
  logic               uses_rr_q, uses_rr_d;
  logic [RR_W-1:0]    rr_q, rr_d;
  logic               kill_q, kill_d;
  ptw_resp_t          resp_q, resp_d;

  logic [WAYS-1:0]    sel_victim;
  logic               sel_uses_rr;

  l2_tlb_victim_sel u_victim_sel (
    .set_valid_i (set_valid),
    .rr_ptr_i    (rr_q),
    .victim_oh_o (sel_victim),
    .uses_rr_o   (sel_uses_rr)
  );

  // State and context registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      vpn_q     <= '0;
      asid_q    <= '0;
      victim_q  <= '0;
      uses_rr_q <= 1'b0;
      rr_q      <= '0;
      kill_q    <= 1'b0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      vpn_q     <= vpn_d;
      asid_q    <= asid_d;
      victim_q  <= victim_d;
      uses_rr_q <= uses_rr_d;
      rr_q      <= rr_d;
      kill_q    <= kill_d;
      resp_q    <= resp_d;
    end
  end

  // Next-state and handshake/strobe decode.
  always_comb begin
    state_d       = state_q;
    vpn_d         = vpn_q;
    asid_d        = asid_q;
    victim_d      = victim_q;
    uses_rr_d     = uses_rr_q;
    rr_d          = rr_q;
    kill_d        = kill_q;
    resp_d        = resp_q;
    miss_ready    = 1'b0;
    ptw_req_valid = 1'b0;
    wr_en         = 1'b0;
    done_valid    = 1'b0;
    done_fault    = 1'b0;
    inval_all     = sfence_valid;

    case (state_q)
      ST_IDLE: begin
        miss_ready = !sfence_valid;
        if (miss_valid && !sfence_valid) begin
          vpn_d     = miss_vpn;
          asid_d    = miss_asid;
          victim_d  = sel_victim;
          uses_rr_d = sel_uses_rr;
          kill_d    = 1'b0;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        ptw_req_valid = 1'b1;
        if (sfence_valid) begin
          // A walk accepted on the fence cycle is in flight; absorb its response.
          if (ptw_req_ready) begin
            kill_d  = 1'b1;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (ptw_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sfence_valid) begin
          kill_d = 1'b1;
        end
        if (ptw_resp_valid) begin
          resp_d = '{ppn: ptw_resp_ppn, v: ptw_resp_v, u: ptw_resp_u,
                     sw: ptw_resp_sw, d: ptw_resp_d, err: ptw_resp_err};
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        done_valid = 1'b1;
        kill_d     = 1'b0;
        state_d    = ST_IDLE;
        if (kill_q || sfence_valid) begin
          done_fault = 1'b0;
        end else if (resp_q.err || !resp_q.v) begin
          done_fault = 1'b1;
        end else begin
          wr_en = 1'b1;
          if (uses_rr_q) begin
            rr_d = rr_q + RR_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ptw_req_vpn = vpn_q;
  assign wr_set      = vpn_q[IDX_W-1:0];
  assign wr_way_oh   = victim_q;
  assign wr_tag      = {asid_q, vpn_q[TAG_VPN_MSB:TAG_VPN_LSB]};
  assign wr_valid    = wr_en;
  assign wr_u        = resp_q.u;
  assign wr_sw       = resp_q.sw;
  assign wr_d        = resp_q.d;
  assign wr_ppn      = resp_q.ppn;

endmodule

// File: tb/tb_l2_tlb_refill.sv
// Directed bench for the L2 TLB refill engine.
module tb_l2_tlb_refill;
  import l2_tlb_refill_pkg::*;

  logic              clk;
  logic              reset_n;
  logic              miss_valid;
  logic              miss_ready;
  logic [VPN_W-1:0]  miss_vpn;
  logic [ASID_W-1:0] miss_asid;
  logic [WAYS-1:0]   set_valid;
  logic              ptw_req_valid;
  logic              ptw_req_ready;
  logic [VPN_W-1:0]  ptw_req_vpn;
  logic              ptw_resp_valid;
  logic [PPN_W-1:0]  ptw_resp_ppn;
  logic              ptw_resp_v;
  logic              ptw_resp_u;
  logic              ptw_resp_sw;
  logic              ptw_resp_d;
  logic              ptw_resp_err;
  logic              sfence_valid;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_set;
  logic [WAYS-1:0]   wr_way_oh;
  logic [TAG_W-1:0]  wr_tag;
  logic              wr_valid;
  logic              wr_u;
  logic              wr_sw;
  logic              wr_d;
  logic [PPN_W-1:0]  wr_ppn;
  logic              inval_all;
  logic              done_valid;
  logic              done_fault;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int mon_errs = 0;

  l2_tlb_refill dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .miss_valid     (miss_valid),
    .miss_ready     (miss_ready),
    .miss_vpn       (miss_vpn),
    .miss_asid      (miss_asid),
    .set_valid      (set_valid),
    .ptw_req_valid  (ptw_req_valid),
    .ptw_req_ready  (ptw_req_ready),
    .ptw_req_vpn    (ptw_req_vpn),
    .ptw_resp_valid (ptw_resp_valid),
    .ptw_resp_ppn   (ptw_resp_ppn),
    .ptw_resp_v     (ptw_resp_v),
    .ptw_resp_u     (ptw_resp_u),
    .ptw_resp_sw    (ptw_resp_sw),
    .ptw_resp_d     (ptw_resp_d),
    .ptw_resp_err   (ptw_resp_err),
    .sfence_valid   (sfence_valid),
    .wr_en          (wr_en),
    .wr_set         (wr_set),
    .wr_way_oh      (wr_way_oh),
    .wr_tag         (wr_tag),
    .wr_valid       (wr_valid),
    .wr_u           (wr_u),
    .wr_sw          (wr_sw),
    .wr_d           (wr_d),
    .wr_ppn         (wr_ppn),
    .inval_all      (inval_all),
    .done_valid     (done_valid),
    .done_fault     (done_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Protocol monitor: no response while a request is pending, no write during invalidate.
  always @(negedge clk) begin
    #3;
    if (reset_n) begin
      assert (!(ptw_req_valid && ptw_resp_valid)) else begin
        mon_errs++;
        $error("FAIL resp_in_req: observed 1 expected 0");
      end
      assert (!(wr_en && inval_all)) else begin
        mon_errs++;
        $error("FAIL wr_and_inval: observed 1 expected 0");
      end
    end
  end

  // Full miss->fill sequence with an always-ready PTW; starts and ends on a negedge.
  task automatic run_fill(input string tag, input logic [27:0] vpn, input logic [6:0] asid,
                          input logic [3:0] sv, input logic v, input logic err,
                          input logic exp_we, input logic [3:0] exp_way, input logic exp_fault);
    miss_valid = 1'b1; miss_vpn = vpn; miss_asid = asid; set_valid = sv; ptw_req_ready = 1'b1;
    #1;
    check({tag, "_mready"}, 64'(miss_ready), 64'd1);
    @(negedge clk);
    miss_valid = 1'b0;
    #1;
    check({tag, "_reqv"}, 64'(ptw_req_valid), 64'd1);
    check({tag, "_reqvpn"}, 64'(ptw_req_vpn), 64'(vpn));
    @(negedge clk);
    ptw_resp_valid = 1'b1; ptw_resp_ppn = 20'hABCDE; ptw_resp_v = v; ptw_resp_err = err;
    ptw_resp_u = 1'b0; ptw_resp_sw = 1'b1; ptw_resp_d = 1'b1;
    @(negedge clk);
    ptw_resp_valid = 1'b0;
    #1;
    check({tag, "_wren"}, 64'(wr_en), 64'(exp_we));
    if (exp_we) check({tag, "_way"}, 64'(wr_way_oh), 64'(exp_way));
    check({tag, "_done"}, 64'(done_valid), 64'd1);
    check({tag, "_fault"}, 64'(done_fault), 64'(exp_fault));
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; miss_valid = 1'b0; miss_vpn = '0; miss_asid = '0; set_valid = '0;
    ptw_req_ready = 1'b0; ptw_resp_valid = 1'b0; ptw_resp_ppn = '0; ptw_resp_v = 1'b0;
    ptw_resp_u = 1'b0; ptw_resp_sw = 1'b0; ptw_resp_d = 1'b0; ptw_resp_err = 1'b0;
    sfence_valid = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_mready", 64'(miss_ready), 64'd1);
    check("rst_reqv", 64'(ptw_req_valid), 64'd0);
    check("rst_wren", 64'(wr_en), 64'd0);
    check("rst_done", 64'(done_valid), 64'd0);
    check("rst_inval", 64'(inval_all), 64'd0);
    check("rst_reqvpn", 64'(ptw_req_vpn), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic fill with field-level checks
    miss_valid = 1'b1; miss_vpn = 28'h0000ABC; miss_asid = 7'd3; set_valid = 4'b0000;
    ptw_req_ready = 1'b1;
    #1;
    check("basic_mready", 64'(miss_ready), 64'd1);
    @(negedge clk);
    miss_valid = 1'b0;
    #1;
    check("basic_reqv", 64'(ptw_req_valid), 64'd1);
    check("basic_reqvpn", 64'(ptw_req_vpn), 64'h0000ABC);
    @(negedge clk);
    #1;
    check("basic_wait_reqv", 64'(ptw_req_valid), 64'd0);
    ptw_resp_valid = 1'b1; ptw_resp_ppn = 20'h12345; ptw_resp_v = 1'b1; ptw_resp_u = 1'b1;
    ptw_resp_sw = 1'b1; ptw_resp_d = 1'b0; ptw_resp_err = 1'b0;
    @(negedge clk);
    ptw_resp_valid = 1'b0;
    #1;
    check("basic_wren", 64'(wr_en), 64'd1);
    check("basic_wrvalid", 64'(wr_valid), 64'd1);
    check("basic_set", 64'(wr_set), 64'h3C);
    check("basic_way", 64'(wr_way_oh), 64'b0001);
    check("basic_tag", 64'(wr_tag), 64'h060002A);
    check("basic_ppn", 64'(wr_ppn), 64'h12345);
    check("basic_u", 64'(wr_u), 64'd1);
    check("basic_sw", 64'(wr_sw), 64'd1);
    check("basic_d", 64'(wr_d), 64'd0);
    check("basic_done", 64'(done_valid), 64'd1);
    check("basic_fault", 64'(done_fault), 64'd0);
    @(negedge clk);
    #1;
    check("basic_post_done", 64'(done_valid), 64'd0);
    check("basic_post_mready", 64'(miss_ready), 64'd1);
    @(negedge clk);

    // Round-robin replacement in set 5 with a full set, then wrap
    run_fill("rr0", 28'h0000005, 7'd1, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b0);
    run_fill("rr1", 28'h0000045, 7'd1, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b0);
    run_fill("rr2", 28'h0000085, 7'd1, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b0);
    run_fill("rr3", 28'h00000C5, 7'd1, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b1000, 1'b0);
    run_fill("rr4", 28'h0000105, 7'd1, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b0);
    // Free way chosen without advancing the pointer (still at 1)
    run_fill("free", 28'h0000145, 7'd1, 4'b1011, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b0);
    run_fill("rr5", 28'h0000185, 7'd1, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b0);

    // Faults: access error, then invalid PTE; neither advances rr (now 2)
    run_fill("err", 28'h0000200, 7'd2, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    run_fill("inv", 28'h0000201, 7'd2, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);

    // Backpressure: request held stable for 5 cycles
    miss_valid = 1'b1; miss_vpn = 28'h7654321; miss_asid = 7'd9; set_valid = 4'b0000;
    ptw_req_ready = 1'b0;
    @(negedge clk);
    miss_valid = 1'b0; miss_vpn = 28'h0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_reqv", 64'(ptw_req_valid), 64'd1);
      check("bp_reqvpn", 64'(ptw_req_vpn), 64'h7654321);
      check("bp_mready", 64'(miss_ready), 64'd0);
      @(negedge clk);
    end
    ptw_req_ready = 1'b1;
    #1;
    check("bp_reqv_final", 64'(ptw_req_valid), 64'd1);
    @(negedge clk);
    ptw_resp_valid = 1'b1; ptw_resp_v = 1'b1; ptw_resp_err = 1'b0; ptw_resp_ppn = 20'h00F0F;
    @(negedge clk);
    ptw_resp_valid = 1'b0;
    #1;
    check("bp_wren", 64'(wr_en), 64'd1);
    check("bp_ppn", 64'(wr_ppn), 64'h00F0F);
    check("bp_set", 64'(wr_set), 64'h21);
    @(negedge clk);

    // Sfence while waiting for the walk: fill is killed, no fault
    miss_valid = 1'b1; miss_vpn = 28'h0000300; miss_asid = 7'd4; set_valid = 4'b0000;
    @(negedge clk);
    miss_valid = 1'b0;
    @(negedge clk);
    sfence_valid = 1'b1;
    #1;
    check("sfw_inval", 64'(inval_all), 64'd1);
    check("sfw_wren", 64'(wr_en), 64'd0);
    @(negedge clk);
    sfence_valid = 1'b0;
    ptw_resp_valid = 1'b1; ptw_resp_v = 1'b1; ptw_resp_err = 1'b0;
    #1;
    check("sfw_inval_clr", 64'(inval_all), 64'd0);
    @(negedge clk);
    ptw_resp_valid = 1'b0;
    #1;
    check("sfw_wren_fill", 64'(wr_en), 64'd0);
    check("sfw_done", 64'(done_valid), 64'd1);
    check("sfw_fault", 64'(done_fault), 64'd0);
    @(negedge clk);

    // Sfence while the request is pending: request dropped, no done
    miss_valid = 1'b1; miss_vpn = 28'h0000301; set_valid = 4'b0000; ptw_req_ready = 1'b0;
    @(negedge clk);
    miss_valid = 1'b0; sfence_valid = 1'b1;
    #1;
    check("sfr_inval", 64'(inval_all), 64'd1);
    @(negedge clk);
    sfence_valid = 1'b0;
    #1;
    check("sfr_reqv", 64'(ptw_req_valid), 64'd0);
    check("sfr_mready", 64'(miss_ready), 64'd1);
    check("sfr_done", 64'(done_valid), 64'd0);
    @(negedge clk);

    // Sfence in IDLE blocks the miss for that cycle
    miss_valid = 1'b1; sfence_valid = 1'b1;
    #1;
    check("sfi_mready", 64'(miss_ready), 64'd0);
    @(negedge clk);
    miss_valid = 1'b0; sfence_valid = 1'b0;
    #1;
    check("sfi_reqv", 64'(ptw_req_valid), 64'd0);
    @(negedge clk);

    // Reset while waiting: late response ignored, rr pointer back to 0
    miss_valid = 1'b1; miss_vpn = 28'h0000305; set_valid = 4'b1111; ptw_req_ready = 1'b1;
    @(negedge clk);
    miss_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rstw_mready", 64'(miss_ready), 64'd1);
    check("rstw_reqv", 64'(ptw_req_valid), 64'd0);
    ptw_resp_valid = 1'b1; ptw_resp_v = 1'b1; ptw_resp_err = 1'b0;
    @(negedge clk);
    ptw_resp_valid = 1'b0;
    #1;
    check("rstw_wren", 64'(wr_en), 64'd0);
    check("rstw_done", 64'(done_valid), 64'd0);
    @(negedge clk);
    run_fill("rstw_rr", 28'h0000345, 7'd5, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b0);

    check("protocol_monitor", 64'(mon_errs), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/l2_tlb_refill.md
Name: l2_tlb_refill

Overview:
Refill engine for the 4-way, 64-set L2 TLB; the write-side counterpart of the L2 TLB lookup. It accepts a miss (ASID + VPN), issues one page-table-walker request, and on the PTW response writes tag, valid, U, SW, D and PPN into one way of the indexed set. It also executes SFENCE (invalidate-all) and prevents stale fills from crossing a fence.

Parameters:
WAYS, 4, associativity; replacement pointer width is log2(WAYS)
SETS, 64, sets; set index = vpn[5:0]
ASID_W, 7, ASID width
VPN_W, 28, VPN width
PPN_W, 20, PPN width

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
miss_valid  in  1  lookup reported L2 miss for current request
miss_ready  out  1  engine can accept a miss (state IDLE, no sfence this cycle)
miss_vpn  in  VPN_W  missing VPN
miss_asid  in  ASID_W  ASID at time of miss
set_valid  in  WAYS  valid bits of set miss_vpn[5:0], sampled with miss
ptw_req_valid  out  1  walk request
ptw_req_ready  in  1  PTW accepts request
ptw_req_vpn  out  VPN_W  VPN to walk (registered)
ptw_resp_valid  in  1  walk complete (single-cycle pulse)
ptw_resp_ppn  in  PPN_W  leaf PPN
ptw_resp_v  in  1  PTE valid
ptw_resp_u  in  1  PTE user
ptw_resp_sw  in  1  PTE writable
ptw_resp_d  in  1  PTE dirty
ptw_resp_err  in  1  walk access fault
sfence_valid  in  1  invalidate all entries
wr_en  out  1  array write strobe
wr_set  out  6  set index
wr_way_oh  out  WAYS  one-hot way select
wr_tag  out  28  {asid, vpn[26:6]}
wr_valid, wr_u, wr_sw, wr_d  out  1 each  entry bits
wr_ppn  out  PPN_W  entry PPN
inval_all  out  1  clear all valid bits this cycle
done_valid  out  1  refill finished (one-cycle pulse)
done_fault  out  1  qualifies done_valid: walk faulted, nothing written

Behaviour:
- Reset (reset_n=0 at clk edge): state IDLE, rr_ptr=0, kill=0; all outputs 0 except miss_ready=1.
- States: IDLE, REQ, WAIT, FILL.
- IDLE: miss_valid&miss_ready -> latch vpn, asid, set_valid; victim = lowest-index invalid way of set_valid, else rr_ptr; -> REQ.
- REQ: ptw_req_valid=1, ptw_req_vpn stable until handshake; valid&ready -> WAIT. Request never withdrawn except by sfence.
- WAIT: ptw_resp_valid -> FILL (latch response). Response in REQ is a protocol error (ignored; assertion in bench).
- FILL (exactly one cycle): if !kill & !err & v: wr_en=1, wr_valid=1, fields from latched response, wr_way_oh=victim; if victim came from rr_ptr, rr_ptr increments mod WAYS. done_valid=1; done_fault = err | !v. If kill: no write, done_valid=1, done_fault=0 (requester replays). -> IDLE, kill cleared.
- Latency with ready PTW: miss accepted cycle 0, ptw_req_valid cycle 1, write/done in cycle after resp.
- sfence_valid: inval_all=1 in same cycle (combinational from registered-free input, one cycle per pulse). IDLE: miss not accepted that cycle (miss_ready=0). REQ: request dropped, -> IDLE, done_valid=0. WAIT: kill=1, stay WAIT until response. FILL: write suppressed (sfence wins over fill), done_fault=0.
- rr_ptr wraps WAYS-1 -> 0; unaffected by sfence.
- Only one outstanding walk; wr_en and inval_all never both 1.

Decomposition:
- Shared package: state encoding, SETS/WAYS/ASID_W/VPN_W/PPN_W, tag width (ASID_W+21), set-index slice constants.
- Sub-module: l2_tlb_victim_sel (set_valid + rr_ptr -> one-hot victim, uses_rr flag).

Test Plan:
- Basic fill: miss vpn=0x0000ABC, asid=3, set_valid=0000, PTW ready, resp ppn=0x12345 v=1 u=1 sw=1 d=0 -> cycle 1 req vpn=0x0000ABC; FILL: wr_set=0x3C, wr_way_oh=0001, wr_tag={3,vpn[26:6]}, done_valid=1, done_fault=0.
- Replacement: four fills to set 5 with set_valid=1111 -> ways 0,1,2,3 then 0 (rr wrap); set_valid=1011 -> way 2 without rr advance.
- Fault: resp err=1 (and separately v=0) -> wr_en=0, done_valid=1, done_fault=1.
- Backpressure: ptw_req_ready low 5 cycles -> ptw_req_valid held, vpn stable, miss_ready=0 throughout.
- Sfence in WAIT then resp -> inval_all pulse, no wr_en, done_fault=0; sfence in REQ -> req drops next cycle, IDLE, no done.
- Reset mid-WAIT: reset_n=0 one cycle -> IDLE, miss_ready=1, later resp ignored, rr_ptr=0.
